prog_word_sequencer: RTL and testbench

// - Upstream feeder of synaptic_core and neuron_core SRAM programming ports: accepts whole memory words
//   (32b synapse row / 128b neuron state) over valid/ready, serialises them into byte-wide

---
 rtl/prog_word_sequencer_pkg.sv | 18 +
 rtl/prog_word_sequencer_if.sv | 42 ++++
 rtl/prog_word_sequencer_byte_mux.sv | 24 ++
 rtl/prog_word_sequencer.sv | 175 +++++++++++++++++
 tb/tb_prog_word_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_word_sequencer_pkg.sv
// Shared types and constants for the SRAM programming word sequencer.
package prog_pkg;

    typedef enum logic [2:0] {IDLE, BYTE, RD_REQ, RD_CMP, GAP} prog_state_t;

    localparam int unsigned SYN_BYTES     = 4;
    localparam int unsigned NEUR_BYTES    = 16;
    localparam int unsigned SYN_LANE_LSB  = 13;
    localparam int unsigned NEUR_LANE_LSB = 8;
    localparam int unsigned ROW_W         = 13;
    localparam int unsigned WORD_W        = 128;

    // Index of the final byte of a word for the given target (0 = synapse, 1 = neuron).
    function automatic logic [3:0] last_byte(input logic target);
        return target ? 4'(NEUR_BYTES - 1) : 4'(SYN_BYTES - 1);
    endfunction

endpackage

// File: rtl/prog_word_sequencer_if.sv
// Command, SRAM control and readback bundle of the word sequencer.
interface prog_word_sequencer_if #(
    parameter int unsigned M = 8
);
    import prog_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_target;
    logic [ROW_W-1:0]  cmd_addr;
    logic [WORD_W-1:0] cmd_wdata;

    logic              ctrl_synarray_cs;
    logic              ctrl_synarray_we;
    logic [ROW_W-1:0]  ctrl_synarray_addr;
    logic              ctrl_neurmem_cs;
    logic              ctrl_neurmem_we;
    logic [M-1:0]      ctrl_neurmem_addr;
    logic [2*M-1:0]    ctrl_spi_addr;
    logic [2*M-1:0]    ctrl_prog_data;

    logic              prog_busy;
    logic              prog_done;
    logic [31:0]       synarray_rdata;
    logic [WORD_W-1:0] neur_state;
    logic              prog_mismatch;

    modport master (
        output cmd_valid, cmd_target, cmd_addr, cmd_wdata, synarray_rdata, neur_state,
        input  cmd_ready, ctrl_synarray_cs, ctrl_synarray_we, ctrl_synarray_addr,
               ctrl_neurmem_cs, ctrl_neurmem_we, ctrl_neurmem_addr, ctrl_spi_addr,
               ctrl_prog_data, prog_busy, prog_done, prog_mismatch
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_addr, cmd_wdata, synarray_rdata, neur_state,
        output cmd_ready, ctrl_synarray_cs, ctrl_synarray_we, ctrl_synarray_addr,
               ctrl_neurmem_cs, ctrl_neurmem_we, ctrl_neurmem_addr, ctrl_spi_addr,
               ctrl_prog_data, prog_busy, prog_done, prog_mismatch
    );

endinterface

// File: rtl/prog_word_sequencer_byte_mux.sv
// Picks the current byte of the captured word and forms the matching byte-lane select.
module prog_byte_mux
    import prog_pkg::*;
#(
    parameter int unsigned M = 8
) (
    input  logic [WORD_W-1:0] word,
    input  logic              target,
    input  logic [3:0]        byte_idx,
    output logic [7:0]        byte_val,
    output logic [2*M-1:0]    lane
);

    always_comb begin
        byte_val = word[{byte_idx, 3'b000} +: 8];
        lane     = '0;
        if (target) begin
            lane[NEUR_LANE_LSB +: 4] = byte_idx;
        end else begin
            lane[SYN_LANE_LSB +: 2] = byte_idx[1:0];
        end
    end

endmodule

// File: rtl/prog_word_sequencer.sv
// Serialises whole synapse/neuron words into byte-wide SRAM programming writes.
// Optional PROG_READBACK_EN adds a read-back compare with a sticky mismatch flag.
module prog_word_sequencer
    import prog_pkg::*;
#(
    parameter int unsigned N        = 256,
    parameter int unsigned M        = 8,
    parameter int unsigned BYTE_CYC = 2,
    parameter int unsigned GAP_CYC  = 1
) (
    input logic                  clk,
    input logic                  rst_sync,
    prog_word_sequencer_if.slave bus
);

    localparam logic [7:0] BYTE_LAST = 8'(BYTE_CYC - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);
    localparam bit         HAS_GAP   = (GAP_CYC != 0);

    if (BYTE_CYC < 1) begin : g_bad_byte_cyc
        $error("BYTE_CYC must be at least 1");
    end
    if (N > (1 << M)) begin : g_bad_n
        $error("N does not fit in M address bits");
    end

    prog_state_t       state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0]        idx_q, idx_d;
    logic              target_q, target_d;
    logic [ROW_W-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              done_q, done_d;
    prog_state_t       after_bytes;

    logic [7:0]        mux_byte;
    logic [2*M-1:0]    mux_lane;

    prog_byte_mux #(
        .M (M)
    ) u_byte_mux (
        .word     (word_q),
        .target   (target_q),
        .byte_idx (idx_q),
        .byte_val (mux_byte),
        .lane     (mux_lane)
    );

`ifdef PROG_READBACK_EN
    logic mismatch_q, mismatch_d, rb_bad;
    assign after_bytes = RD_REQ;
    assign rb_bad = target_q ? (bus.neur_state != word_q)
                             : (bus.synarray_rdata != word_q[31:0]);
    assign bus.prog_mismatch = mismatch_q;

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end
`else
    logic unused_readback;
    assign after_bytes = HAS_GAP ? GAP : IDLE;
    assign unused_readback = ^{bus.synarray_rdata, bus.neur_state};
    assign bus.prog_mismatch = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            target_q <= 1'b0;
            addr_q   <= '0;
            word_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            target_q <= target_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        target_d = target_q;
        addr_d   = addr_q;
        word_d   = word_q;
`ifdef PROG_READBACK_EN
        mismatch_d = mismatch_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d  = BYTE;
                    cnt_d    = '0;
                    idx_d    = '0;
                    target_d = bus.cmd_target;
                    addr_d   = bus.cmd_addr;
                    word_d   = bus.cmd_wdata;
                end
            end
            BYTE: begin
                if (cnt_q == BYTE_LAST) begin
                    cnt_d = '0;
                    if (idx_q == last_byte(target_q)) begin
                        state_d = after_bytes;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef PROG_READBACK_EN
            RD_REQ: state_d = RD_CMP;
            RD_CMP: begin
                if (rb_bad) begin
                    mismatch_d = 1'b1;
                end
                state_d = HAS_GAP ? GAP : IDLE;
            end
`endif
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Done pulses in the first IDLE cycle after a word, where a new command may already land.
        done_d = (state_q != IDLE) && (state_d == IDLE);
    end

    always_comb begin
        bus.cmd_ready          = (state_q == IDLE);
        bus.prog_busy          = (state_q != IDLE);
        bus.prog_done          = done_q;
        bus.ctrl_synarray_cs   = 1'b0;
        bus.ctrl_synarray_we   = 1'b0;
        bus.ctrl_synarray_addr = '0;
        bus.ctrl_neurmem_cs    = 1'b0;
        bus.ctrl_neurmem_we    = 1'b0;
        bus.ctrl_neurmem_addr  = '0;
        bus.ctrl_spi_addr      = '0;
        bus.ctrl_prog_data     = '0;
        if (state_q != IDLE) begin
            if (target_q) begin
                bus.ctrl_neurmem_cs   = 1'b1;
                bus.ctrl_neurmem_we   = (state_q == BYTE);
                bus.ctrl_neurmem_addr = addr_q[M-1:0];
            end else begin
                bus.ctrl_synarray_cs   = 1'b1;
                bus.ctrl_synarray_we   = (state_q == BYTE);
                bus.ctrl_synarray_addr = addr_q;
            end
        end
        if (state_q == BYTE) begin
            bus.ctrl_spi_addr  = mux_lane;
            bus.ctrl_prog_data = {{(2*M-8){1'b0}}, mux_byte};
        end
    end

endmodule

// File: tb/tb_prog_word_sequencer.sv
// Self-checking bench: per-cycle schedule model of the sequencer plus directed literal checks.
module tb_prog_word_sequencer;
    import prog_pkg::*;

    localparam int unsigned BC = 2;
    localparam int unsigned GC = 1;
`ifdef PROG_READBACK_EN
    localparam int RB = 2;
`else
    localparam int RB = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_word_sequencer_if #(.M(8)) bus ();

    prog_word_sequencer #(
        .N        (256),
        .M        (8),
        .BYTE_CYC (BC),
        .GAP_CYC  (GC)
    ) dut (
        .clk      (clk),
        .rst_sync (rst),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model of the word in flight: when it was accepted and what it carries.
    bit           checking = 0;
    bit           m_active = 0;
    int           m_t0     = 0;
    bit           m_tgt    = 0;
    logic [12:0]  m_addr   = '0;
    logic [127:0] m_data   = '0;
    bit           m_corrupt = 0;
    bit           m_mis    = 0;
    bit           corrupt_next = 0;

    // Memory read-back: returns the programmed word, byte 5 flipped when flagged corrupt.
    assign bus.neur_state     = m_data ^ (m_corrupt ? (128'hFF << 40) : 128'h0);
    assign bus.synarray_rdata = m_data[31:0];

    int accept_log[$];
    int done_log[$];
    logic [31:0] byte_log[$];
    int syn_we_cnt  = 0;
    int neur_we_cnt = 0;

    function automatic logic [60:0] pack(input logic rdy, input logic busy, input logic done,
                                         input logic mis, input logic scs, input logic swe,
                                         input logic [12:0] sa, input logic ncs, input logic nwe,
                                         input logic [7:0] na, input logic [15:0] spi,
                                         input logic [15:0] dat);
        return {rdy, busy, done, mis, scs, swe, sa, ncs, nwe, na, spi, dat};
    endfunction

    function automatic int word_len(input bit tgt);
        return (tgt ? 16 : 4) * BC + RB + GC + 1;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic        e_rdy, e_busy, e_done, e_scs, e_swe, e_ncs, e_nwe;
    logic [12:0] e_sa;
    logic [7:0]  e_na;
    logic [15:0] e_spi, e_dat;
    int          off, nb, k;

    always @(negedge clk) begin
        if (checking) begin
            e_rdy = 1; e_busy = 0; e_done = 0;
            e_scs = 0; e_swe = 0; e_sa = '0;
            e_ncs = 0; e_nwe = 0; e_na = '0;
            e_spi = '0; e_dat = '0;
            off = 0;
            nb  = m_tgt ? 16 : 4;
            if (m_active) begin
                off = cyc - m_t0;
                if (off == word_len(m_tgt)) begin
                    e_done = 1;
                end else if (off >= 1 && off < word_len(m_tgt)) begin
                    e_rdy  = 0;
                    e_busy = 1;
                    if (m_tgt) begin e_ncs = 1; e_na = m_addr[7:0]; end
                    else       begin e_scs = 1; e_sa = m_addr;      end
                    if (off <= nb * BC) begin
                        k = (off - 1) / BC;
                        if (m_tgt) begin e_nwe = 1; e_spi = 16'(k << 8);  end
                        else       begin e_swe = 1; e_spi = 16'(k << 13); end
                        e_dat = {8'h00, m_data[8*k +: 8]};
                    end
                end
            end
            chk("cycle_outputs",
                pack(bus.cmd_ready, bus.prog_busy, bus.prog_done, bus.prog_mismatch,
                     bus.ctrl_synarray_cs, bus.ctrl_synarray_we, bus.ctrl_synarray_addr,
                     bus.ctrl_neurmem_cs, bus.ctrl_neurmem_we, bus.ctrl_neurmem_addr,
                     bus.ctrl_spi_addr, bus.ctrl_prog_data),
                pack(e_rdy, e_busy, e_done, m_mis, e_scs, e_swe, e_sa, e_ncs, e_nwe, e_na,
                     e_spi, e_dat));

            if (bus.cmd_valid && bus.cmd_ready) accept_log.push_back(cyc);
            if (bus.prog_done) done_log.push_back(cyc);
            if (bus.ctrl_synarray_we) syn_we_cnt++;
            if (bus.ctrl_neurmem_we) neur_we_cnt++;
            if (bus.ctrl_synarray_we || bus.ctrl_neurmem_we)
                byte_log.push_back({bus.ctrl_spi_addr, bus.ctrl_prog_data});

            if (m_active && RB != 0 && m_corrupt && off == nb * BC + 2) m_mis = 1;
            if (m_active && off >= word_len(m_tgt)) m_active = 0;
            if (rst) begin
                m_active = 0;
                m_mis    = 0;
            end else if (bus.cmd_valid && e_rdy) begin
                m_active  = 1;
                m_t0      = cyc;
                m_tgt     = bus.cmd_target;
                m_addr    = bus.cmd_addr;
                m_data    = bus.cmd_wdata;
                m_corrupt = corrupt_next;
            end
        end
    end

    task automatic clear_logs();
        accept_log.delete();
        done_log.delete();
        byte_log.delete();
        syn_we_cnt  = 0;
        neur_we_cnt = 0;
    endtask

    task automatic present(input bit tgt, input logic [12:0] addr, input logic [127:0] data,
                           input bit bad);
        bus.cmd_valid  = 1;
        bus.cmd_target = tgt;
        bus.cmd_addr   = addr;
        bus.cmd_wdata  = data;
        corrupt_next   = bad;
    endtask

    // Returns #1 after the accepting edge with cmd_valid dropped.
    task automatic wait_accept(input string name);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin ok = 1; break; end
        end
        @(posedge clk);
        #1 bus.cmd_valid = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: handshake not seen within 200 cycles, required ready=1", name);
        end
    endtask

    task automatic wait_done(input string name, input int count);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (done_log.size() >= count) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d done pulses, required %0d", name, done_log.size(), count);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid  = 0;
        bus.cmd_target = 0;
        bus.cmd_addr   = '0;
        bus.cmd_wdata  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        checking = 1;
        @(negedge clk);
        chk("reset_ready", bus.cmd_ready, 1);
        chk("reset_busy", bus.prog_busy, 0);
        chk("reset_cs", {bus.ctrl_synarray_cs, bus.ctrl_neurmem_cs}, 0);

        // Synapse word to row 0x041
        clear_logs();
        @(posedge clk); #1;
        present(0, 13'h041, 128'hA1B2C3D4, 0);
        wait_accept("syn_accept");
        wait_done("syn_done", 1);
        chk("syn_we_cycles", syn_we_cnt, 8);
        chk("syn_neur_we_cycles", neur_we_cnt, 0);
        chk("syn_latency", done_log[0] - accept_log[0], 10 + RB);
        chk("syn_byte0", byte_log[0], 32'h0000_00D4);
        chk("syn_byte1", byte_log[2], 32'h2000_00C3);
        chk("syn_byte2", byte_log[4], 32'h4000_00B2);
        chk("syn_byte3", byte_log[6], 32'h6000_00A1);

        // Neuron word, byte k = k, to row 0x08
        clear_logs();
        present(1, 13'h008, 128'h0F0E0D0C0B0A09080706050403020100, 0);
        wait_accept("neur_accept");
        wait_done("neur_done", 1);
        chk("neur_we_cycles", neur_we_cnt, 32);
        chk("neur_syn_we_cycles", syn_we_cnt, 0);
        chk("neur_latency", done_log[0] - accept_log[0], 34 + RB);
        chk("neur_byte5", byte_log[10], 32'h0500_0005);
        chk("neur_byte15", byte_log[30], 32'h0F00_000F);

        // Back-to-back words; second held valid while the first is in flight
        clear_logs();
        present(0, 13'h1FFF, 128'h0102_0304, 0);
        wait_accept("b2b_first");
        present(0, 13'h0005, 128'hDEAD_BEEF, 0);
        @(negedge clk);
        chk("hold_ready_low", bus.cmd_ready, 0);
        wait_accept("b2b_second");
        wait_done("b2b_done", 2);
        chk("b2b_accept_in_done", accept_log[1], done_log[0]);
        chk("b2b_spacing", done_log[1] - done_log[0], 10 + RB);
        chk("b2b_second_byte0", byte_log[8], 32'h0000_00EF);

        // Reset while byte 2 of a synapse word is on the bus
        clear_logs();
        present(0, 13'h0123, 128'h1122_3344, 0);
        wait_accept("rst_accept");
        repeat (4) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_abort_cs_we", {bus.ctrl_synarray_cs, bus.ctrl_synarray_we}, 2'b00);
        chk("rst_abort_ready", bus.cmd_ready, 1);
        chk("rst_abort_byte2_seen", byte_log[4], 32'h4000_0022);
        repeat (20) @(posedge clk);
        chk("rst_no_done", done_log.size(), 0);

`ifdef PROG_READBACK_EN
        // Corrupted neuron read-back, then a clean word: flag must stay set
        clear_logs();
        @(posedge clk); #1;
        present(1, 13'h0033, 128'h0F0E0D0C0B0A09080706050403020100, 1);
        wait_accept("rb_bad_accept");
        wait_done("rb_bad_done", 1);
        chk("rb_mismatch_set", bus.prog_mismatch, 1);
        present(0, 13'h0002, 128'h5566_7788, 0);
        wait_accept("rb_good_accept");
        wait_done("rb_good_done", 2);
        chk("rb_mismatch_sticky", bus.prog_mismatch, 1);
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
